input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_if.sv | 37 +++
 rtl/input_conditioner.sv | 161 ++++++++++++++++
 tb/tb_input_conditioner.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/input_conditioner_if.sv
// Signal bundle between the raw button/switch inputs and their conditioned outputs.
// All outputs are level or single-cycle strobe signals; there is no backpressure.
interface input_conditioner_if;
   logic       button_raw;
   logic [2:0] switch_raw;
   logic       button_level;
   logic       press_pulse;
   logic       release_pulse;
   logic       long_press_pulse;
   logic [2:0] switch_stable;
   logic       switch_change_pulse;
   logic [1:0] btn_state;

   modport master (
      output button_raw,
      output switch_raw,
      input  button_level,
      input  press_pulse,
      input  release_pulse,
      input  long_press_pulse,
      input  switch_stable,
      input  switch_change_pulse,
      input  btn_state
   );

   modport slave (
      input  button_raw,
      input  switch_raw,
      output button_level,
      output press_pulse,
      output release_pulse,
      output long_press_pulse,
      output switch_stable,
      output switch_change_pulse,
      output btn_state
   );
endinterface

// File: rtl/input_conditioner.sv
// Synchronizes and debounces a push-button (with press/release/long-press strobes)
// and a 3-bit slide switch bank; the two paths are fully independent.
module input_conditioner #(
   parameter logic [31:0] DEBOUNCE_CYCLES   = 32'd1000000,
   parameter logic [31:0] LONG_PRESS_CYCLES = 32'd100000000
) (
   input logic                clk,
   input logic                rst_n,
   input_conditioner_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_e;

   localparam logic [31:0] DEB_LAST  = DEBOUNCE_CYCLES - 32'd1;
   localparam logic [31:0] LONG_LAST = LONG_PRESS_CYCLES - 32'd1;

   logic       btn_meta_q;
   logic       btn_s_q;
   logic [2:0] sw_meta_q;
   logic [2:0] sw_s_q;
   logic [2:0] sw_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_meta_q <= 1'b0;
         btn_s_q    <= 1'b0;
         sw_meta_q  <= 3'b000;
         sw_s_q     <= 3'b000;
         sw_prev_q  <= 3'b000;
      end else begin
         btn_meta_q <= bus.button_raw;
         btn_s_q    <= btn_meta_q;
         sw_meta_q  <= bus.switch_raw;
         sw_s_q     <= sw_meta_q;
         sw_prev_q  <= sw_s_q;
      end
   end

   btn_state_e  state_q;
   logic [31:0] deb_cnt_q;
   logic [31:0] hold_cnt_q;
   logic        level_q;
   logic        press_q;
   logic        release_q;
   logic        long_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         deb_cnt_q  <= 32'd0;
         hold_cnt_q <= 32'd0;
         level_q    <= 1'b0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         long_q     <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (btn_s_q) begin
                  state_q   <= PRESS_WAIT;
                  deb_cnt_q <= 32'd0;
               end
            end
            PRESS_WAIT: begin
               if (!btn_s_q) begin
                  state_q   <= IDLE;
                  deb_cnt_q <= 32'd0;
               end else if (deb_cnt_q == DEB_LAST) begin
                  state_q    <= PRESSED;
                  deb_cnt_q  <= 32'd0;
                  hold_cnt_q <= 32'd0;
                  level_q    <= 1'b1;
                  press_q    <= 1'b1;
               end else begin
                  deb_cnt_q <= deb_cnt_q + 32'd1;
               end
            end
            PRESSED: begin
               if (!btn_s_q) begin
                  state_q   <= RELEASE_WAIT;
                  deb_cnt_q <= 32'd0;
               end else if (hold_cnt_q != LONG_PRESS_CYCLES) begin
                  // Saturation at the limit guarantees a single long-press strobe.
                  hold_cnt_q <= hold_cnt_q + 32'd1;
                  if (hold_cnt_q == LONG_LAST) begin
                     long_q <= 1'b1;
                  end
               end
            end
            RELEASE_WAIT: begin
               if (btn_s_q) begin
                  // Release glitch: resume the press with hold timing intact.
                  state_q <= PRESSED;
               end else if (deb_cnt_q == DEB_LAST) begin
                  state_q   <= IDLE;
                  deb_cnt_q <= 32'd0;
                  level_q   <= 1'b0;
                  release_q <= 1'b1;
               end else begin
                  deb_cnt_q <= deb_cnt_q + 32'd1;
               end
            end
            default: begin
               state_q   <= IDLE;
               deb_cnt_q <= 32'd0;
            end
         endcase
      end
   end

   logic [31:0] sw_cnt_d, sw_cnt_q;
   logic [2:0]  sw_stable_d, sw_stable_q;
   logic        sw_pulse_d, sw_pulse_q;

   always_comb begin
      sw_cnt_d    = sw_cnt_q;
      sw_stable_d = sw_stable_q;
      sw_pulse_d  = 1'b0;
      if (sw_s_q == sw_stable_q) begin
         sw_cnt_d = 32'd0;
      end else if (sw_s_q != sw_prev_q) begin
         // New candidate value: restart the stability count.
         sw_cnt_d = 32'd0;
      end else if (sw_cnt_q == DEB_LAST) begin
         sw_cnt_d    = 32'd0;
         sw_stable_d = sw_s_q;
         sw_pulse_d  = 1'b1;
      end else begin
         sw_cnt_d = sw_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_cnt_q    <= 32'd0;
         sw_stable_q <= 3'b000;
         sw_pulse_q  <= 1'b0;
      end else begin
         sw_cnt_q    <= sw_cnt_d;
         sw_stable_q <= sw_stable_d;
         sw_pulse_q  <= sw_pulse_d;
      end
   end

   assign bus.button_level        = level_q;
   assign bus.press_pulse         = press_q;
   assign bus.release_pulse       = release_q;
   assign bus.long_press_pulse    = long_q;
   assign bus.switch_stable       = sw_stable_q;
   assign bus.switch_change_pulse = sw_pulse_q;
   assign bus.btn_state           = state_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
// Inputs change on the falling edge; cycle k after a change is observed after the k-th rising edge.
module tb_input_conditioner;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   input_conditioner_if bus ();

   input_conditioner #(
      .DEBOUNCE_CYCLES   (32'd4),
      .LONG_PRESS_CYCLES (32'd20)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Steps n cycles; each strobe must be high exactly at its listed cycle (0 = never).
   task automatic watch(input int n, input int press_at, input int rel_at,
                        input int long_at, input int sw_at);
      for (int i = 1; i <= n; i++) begin
         tick();
         check("press_pulse",  32'(bus.press_pulse),         32'(i == press_at));
         check("release_pulse", 32'(bus.release_pulse),      32'(i == rel_at));
         check("long_pulse",   32'(bus.long_press_pulse),    32'(i == long_at));
         check("sw_pulse",     32'(bus.switch_change_pulse), 32'(i == sw_at));
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_level"},  32'(bus.button_level),        32'd0);
      check({tag, "_press"},  32'(bus.press_pulse),         32'd0);
      check({tag, "_rel"},    32'(bus.release_pulse),       32'd0);
      check({tag, "_long"},   32'(bus.long_press_pulse),    32'd0);
      check({tag, "_stable"}, 32'(bus.switch_stable),       32'd0);
      check({tag, "_swp"},    32'(bus.switch_change_pulse), 32'd0);
      check({tag, "_state"},  32'(bus.btn_state),           32'd0);
   endtask

   always @(negedge clk) begin
      check("exclusive", 32'($countones({bus.press_pulse, bus.release_pulse,
                                         bus.long_press_pulse}) <= 1), 32'd1);
   end

   initial begin
      tests_run      = 0;
      tests_failed   = 0;
      rst_n          = 1'b0;
      bus.button_raw = 1'b0;
      bus.switch_raw = 3'b000;
      tick();
      tick();
      check_idle_outputs("reset");
      rst_n = 1'b1;
      watch(4, 0, 0, 0, 0);

      // Clean press, held into a long press, then released.
      bus.button_raw = 1'b1;
      watch(12, 7, 0, 0, 0);
      check("level_pressed", 32'(bus.button_level), 32'd1);
      watch(30, 0, 0, 15, 0);
      bus.button_raw = 1'b0;
      watch(6, 0, 0, 0, 0);
      check("level_before_rel", 32'(bus.button_level), 32'd1);
      watch(6, 0, 1, 0, 0);
      check("level_released", 32'(bus.button_level), 32'd0);

      // Bounce: 3 high, 1 low, then held high.
      bus.button_raw = 1'b1;
      watch(3, 0, 0, 0, 0);
      bus.button_raw = 1'b0;
      watch(1, 0, 0, 0, 0);
      bus.button_raw = 1'b1;
      watch(12, 7, 0, 0, 0);
      bus.button_raw = 1'b0;
      watch(12, 0, 7, 0, 0);

      // Release glitch of 2 cycles pauses but does not restart long-press timing.
      bus.button_raw = 1'b1;
      watch(10, 7, 0, 0, 0);
      bus.button_raw = 1'b0;
      watch(2, 0, 0, 0, 0);
      bus.button_raw = 1'b1;
      watch(25, 0, 0, 18, 0);
      check("level_glitch", 32'(bus.button_level), 32'd1);
      bus.button_raw = 1'b0;
      watch(12, 0, 7, 0, 0);

      // Switch accept, then a toggle too fast to be accepted.
      bus.switch_raw = 3'b101;
      watch(6, 0, 0, 0, 0);
      check("sw_stable_pre", 32'(bus.switch_stable), 32'h0);
      watch(6, 0, 0, 0, 1);
      check("sw_stable_101", 32'(bus.switch_stable), 32'h5);
      for (int k = 0; k < 6; k++) begin
         bus.switch_raw = (k % 2 == 0) ? 3'b000 : 3'b101;
         watch(2, 0, 0, 0, 0);
      end
      watch(8, 0, 0, 0, 0);
      check("sw_stable_toggle", 32'(bus.switch_stable), 32'h5);

      // Simultaneous button and switch events.
      bus.button_raw = 1'b1;
      bus.switch_raw = 3'b011;
      watch(12, 7, 0, 0, 7);
      check("sw_stable_011", 32'(bus.switch_stable), 32'h3);

      // Reset while pressed: no release, fresh press and switch report afterwards.
      bus.switch_raw = 3'b110;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("async_rst");
      @(negedge clk);
      watch(3, 0, 0, 0, 0);
      check_idle_outputs("held_rst");
      rst_n = 1'b1;
      watch(12, 7, 0, 0, 7);
      check("sw_stable_110", 32'(bus.switch_stable), 32'h6);
      check("level_after_rst", 32'(bus.button_level), 32'd1);
      bus.button_raw = 1'b0;
      watch(12, 0, 7, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
